tmr_recovery_sequencer: RTL and testbench
=========================================

Name: tmr_recovery_sequencer

Overview:
- Multi-cycle rollback controller for the TMR RISC-V core.
- On a voter-reported fault it stalls all three replicas and drains the pipeline.
- It then injects one LW reload instruction per architectural register from the recovery data memory, and redirects the PC to the last checkpointed PC.
- It sits between the voter and the PC/fetch mux, and replaces single-cycle rollback-instruction injection with a sequenced, retry-bounded recovery.

Parameters:
- NUM_REGS, 31: registers restored, x1..x31.
- DRAIN_CYCLES, 4: stall cycles before injection starts (pipeline depth).
- CKPT_BASE, 12'h000: byte offset of the register image in recovery memory.
- MAX_RETRY, 2: faults tolerated during RESTORE before declaring failure.
- RESET_PC, 32'h0000_0000: checkpoint PC value after reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Voter_state  in  3  3'b000 = fault, rollback required; any other value = healthy
- PC_voter_output  in  32  voted PC
- Ckpt_en  in  1  commit point; capture PC_voter_output as checkpoint
- Inject_ready  in  1  fetch accepts the injected instruction this cycle
- Stall  out  1  freeze all replicas' fetch/commit
- Inject_valid  out  1  Inject_instr is valid
- Inject_instr  out  32  reload instruction
- Recovery_Data_MemWrite_sel  out  1  route data-memory writes to recovery memory
- Data_Recovery_sel  out  1  route load data from recovery memory
- PC_redirect_valid  out  1  one-cycle PC load strobe
- PC_redirect  out  32  checkpoint PC
- Recovery_busy  out  1  state != IDLE
- Recovery_fail  out  1  sticky unrecoverable-fault flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; ckpt_pc=RESET_PC; reg index r=1; retry=0; drain counter=0.
  - Reset mid-recovery aborts immediately to these values.
- States: IDLE, DRAIN, RESTORE, REDIRECT, FAIL. All outputs are registered and derived from state.
- IDLE:
  - If Ckpt_en=1 and Voter_state!=000, load ckpt_pc<=PC_voter_output.
  - If Voter_state==000, go to DRAIN: Stall=1 from the next cycle (1-cycle latency) and drain counter cleared.
  - Fault and Ckpt_en in the same cycle: the fault wins and no capture occurs.
- Checkpoint capture is blocked in every state except IDLE.
- DRAIN:
  - Stall=1. Counts DRAIN_CYCLES cycles, then goes to RESTORE with r=1.
  - Voter faults here are ignored.
- RESTORE:
  - Stall=1, Inject_valid=1, Data_Recovery_sel=1, Recovery_Data_MemWrite_sel=1.
  - Inject_instr = {imm, 5'b00000, 3'b010, r[4:0], 7'b0000011}, i.e. LW xr, imm(x0).
  - imm = CKPT_BASE + 4*r, truncated to 12 bits (wraps mod 4096).
  - r advances only on Inject_valid & Inject_ready; the instruction is held stable while ready=0.
  - After the handshake with r==NUM_REGS, go to REDIRECT.
  - Fault (Voter_state==000) during RESTORE: retry<=retry+1.
    - If the new retry<=MAX_RETRY: return to DRAIN with r=1.
    - Otherwise go to FAIL.
    - A fault takes priority over a simultaneous handshake.
- REDIRECT:
  - Exactly one cycle: PC_redirect_valid=1, PC_redirect=ckpt_pc, Stall=1, injection deasserted.
  - Next state IDLE; retry cleared. A fault here is handled by IDLE on the following cycle if it persists.
- FAIL:
  - Stall=1, Recovery_fail=1, Recovery_busy=1; all other outputs 0.
  - Exit only by reset.
- Nominal latency with Inject_ready=1 and the fault sampled at edge T:
  - DRAIN occupies T+1..T+DRAIN_CYCLES.
  - RESTORE occupies the next NUM_REGS cycles.
  - REDIRECT at T+DRAIN_CYCLES+NUM_REGS+1.
  - Stall=0 at T+DRAIN_CYCLES+NUM_REGS+2.
- PC_redirect outside REDIRECT: 0.
- Inject_instr outside RESTORE: 0.

Decomposition:
- Shared package tmr_recovery_pkg holds:
  - state enum;
  - VOTER_FAULT=3'b000;
  - OPC_LOAD=7'b0000011;
  - F3_LW=3'b010;
  - function build_lw(rd, imm).
- One sub-module, tmr_ckpt_reg: the checkpoint PC register with capture enable, reset value RESET_PC, and a block-capture input driven by Recovery_busy.

Test Plan:
1. Reset, Ckpt_en pulse with PC=32'h0000_0040, Voter_state=3'b111 -> ckpt_pc=0x40; all outputs 0.
2. Fault at T, Inject_ready=1 -> Stall rises at T+1; first Inject_instr=32'h00402083 (LW x1,4(x0)) at T+5; last instr is x31 imm 0x07C; PC_redirect=0x40 pulse at T+36; Stall=0 at T+37.
3. Inject_ready toggled 1,0,0,1 in RESTORE -> Inject_instr for x2 is held stable across the two stalled cycles; no register is skipped or duplicated.
4. Fault at RESTORE r=10 -> re-DRAIN, restart at r=1; second fault -> restart; third fault -> FAIL, Recovery_fail=1 until rst_n pulse.
5. Ckpt_en=1 during DRAIN with PC=0x80 -> ckpt_pc stays 0x40, and PC_redirect=0x40.
6. rst_n asserted mid-RESTORE -> all outputs 0 asynchronously; after release, IDLE with ckpt_pc=RESET_PC.

Source files
------------

// File: rtl/tmr_recovery_pkg.sv
// Shared types and constants for the TMR rollback/recovery sequencer.
// Holds the sequencer state encoding, voter fault code and LW encoding helper.
// No logic of its own; imported by every recovery RTL file.
package tmr_recovery_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_RESTORE  = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_FAIL     = 3'd4
    } state_t;

    localparam logic [2:0] VOTER_FAULT = 3'b000;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [2:0] F3_LW       = 3'b010;

    // LW rd, imm(x0): I-type with rs1 hard-wired to x0.
    function automatic logic [31:0] build_lw(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'b00000, F3_LW, rd, OPC_LOAD};
    endfunction

endpackage

// File: rtl/tmr_recovery_sequencer_ckpt.sv
// Checkpoint PC register: captures the voted PC at commit points while idle.
// Latency: 1 cycle from capture_en to ckpt_pc update.
// Backpressure: none; capture is simply suppressed while capture_block is high.
// Ports: clk, rst_n, capture_en, capture_block, pc_in[31:0] -> ckpt_pc[31:0].
module tmr_ckpt_reg
    import tmr_recovery_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture_en,
    input  logic        capture_block,
    input  logic [31:0] pc_in,
    output logic [31:0] ckpt_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ckpt_pc <= RESET_PC;
        end else if (capture_en && !capture_block) begin
            ckpt_pc <= pc_in;
        end
    end

endmodule

// File: rtl/tmr_recovery_sequencer.sv
// Rollback controller: on voter fault stalls replicas, drains, reloads x1..xN via
// injected LWs from recovery memory, then redirects PC to the last checkpoint.
// Latency: outputs registered (1 cycle after the deciding edge); injection waits on Inject_ready.
// Ports: clk, rst_n, Voter_state, PC_voter_output, Ckpt_en, Inject_ready in;
//        Stall, Inject_valid/instr, recovery mux selects, PC_redirect(_valid), busy/fail out.
module tmr_recovery_sequencer
    import tmr_recovery_pkg::*;
#(
    parameter int          NUM_REGS     = 31,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [11:0] CKPT_BASE    = 12'h000,
    parameter int          MAX_RETRY    = 2,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  Voter_state,
    input  logic [31:0] PC_voter_output,
    input  logic        Ckpt_en,
    input  logic        Inject_ready,
    output logic        Stall,
    output logic        Inject_valid,
    output logic [31:0] Inject_instr,
    output logic        Recovery_Data_MemWrite_sel,
    output logic        Data_Recovery_sel,
    output logic        PC_redirect_valid,
    output logic [31:0] PC_redirect,
    output logic        Recovery_busy,
    output logic        Recovery_fail
);

    localparam logic [4:0] LAST_REG   = 5'(NUM_REGS);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
    localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRY);

    state_t      state, state_nxt;
    logic [4:0]  r, r_nxt;
    logic [3:0]  retry, retry_nxt;
    logic [7:0]  drain_cnt, drain_nxt;
    logic [31:0] ckpt_pc;
    logic        fault;
    logic [11:0] imm_nxt;

    assign fault = (Voter_state == VOTER_FAULT);

    // A fault in the same cycle as Ckpt_en must not capture: the PC is suspect.
    tmr_ckpt_reg #(
        .RESET_PC (RESET_PC)
    ) u_ckpt (
        .clk           (clk),
        .rst_n         (rst_n),
        .capture_en    (Ckpt_en && !fault),
        .capture_block (Recovery_busy),
        .pc_in         (PC_voter_output),
        .ckpt_pc       (ckpt_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            r         <= 5'd1;
            retry     <= 4'd0;
            drain_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            r         <= r_nxt;
            retry     <= retry_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        retry_nxt = retry;
        drain_nxt = drain_cnt;
        case (state)
            ST_IDLE: begin
                if (fault) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = 8'd0;
                end
            end
            ST_DRAIN: begin
                // Voter output is meaningless while the pipeline empties; ignore it.
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = ST_RESTORE;
                    r_nxt     = 5'd1;
                end else begin
                    drain_nxt = drain_cnt + 8'd1;
                end
            end
            ST_RESTORE: begin
                // Fault beats a simultaneous handshake: the reload in flight is untrusted.
                if (fault) begin
                    retry_nxt = retry + 4'd1;
                    if (retry_nxt <= RETRY_MAX) begin
                        state_nxt = ST_DRAIN;
                        drain_nxt = 8'd0;
                        r_nxt     = 5'd1;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
                end else if (Inject_valid && Inject_ready) begin
                    if (r == LAST_REG) begin
                        state_nxt = ST_REDIRECT;
                    end else begin
                        r_nxt = r + 5'd1;
                    end
                end
            end
            ST_REDIRECT: begin
                state_nxt = ST_IDLE;
                retry_nxt = 4'd0;
            end
            ST_FAIL: begin
                state_nxt = ST_FAIL;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign imm_nxt = CKPT_BASE + {5'b00000, r_nxt, 2'b00};

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Stall                      <= 1'b0;
            Inject_valid               <= 1'b0;
            Inject_instr               <= 32'd0;
            Recovery_Data_MemWrite_sel <= 1'b0;
            Data_Recovery_sel          <= 1'b0;
            PC_redirect_valid          <= 1'b0;
            PC_redirect                <= 32'd0;
            Recovery_busy              <= 1'b0;
            Recovery_fail              <= 1'b0;
        end else begin
            Stall                      <= (state_nxt != ST_IDLE);
            Recovery_busy              <= (state_nxt != ST_IDLE);
            Inject_valid               <= (state_nxt == ST_RESTORE);
            Recovery_Data_MemWrite_sel <= (state_nxt == ST_RESTORE);
            Data_Recovery_sel          <= (state_nxt == ST_RESTORE);
            Inject_instr               <= (state_nxt == ST_RESTORE) ? build_lw(r_nxt, imm_nxt) : 32'd0;
            PC_redirect_valid          <= (state_nxt == ST_REDIRECT);
            PC_redirect                <= (state_nxt == ST_REDIRECT) ? ckpt_pc : 32'd0;
            Recovery_fail              <= (state_nxt == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_tmr_recovery_sequencer.sv
// Directed bench for tmr_recovery_sequencer: checkpoint capture, nominal recovery
// timing, ready backpressure, retry exhaustion to FAIL, capture blocking, async reset.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_tmr_recovery_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  Voter_state = 3'b111;
    logic [31:0] PC_voter_output = 32'd0;
    logic        Ckpt_en = 1'b0;
    logic        Inject_ready = 1'b1;
    logic        Stall;
    logic        Inject_valid;
    logic [31:0] Inject_instr;
    logic        Recovery_Data_MemWrite_sel;
    logic        Data_Recovery_sel;
    logic        PC_redirect_valid;
    logic [31:0] PC_redirect;
    logic        Recovery_busy;
    logic        Recovery_fail;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmr_recovery_sequencer dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .Voter_state                (Voter_state),
        .PC_voter_output            (PC_voter_output),
        .Ckpt_en                    (Ckpt_en),
        .Inject_ready               (Inject_ready),
        .Stall                      (Stall),
        .Inject_valid               (Inject_valid),
        .Inject_instr               (Inject_instr),
        .Recovery_Data_MemWrite_sel (Recovery_Data_MemWrite_sel),
        .Data_Recovery_sel          (Data_Recovery_sel),
        .PC_redirect_valid          (PC_redirect_valid),
        .PC_redirect                (PC_redirect),
        .Recovery_busy              (Recovery_busy),
        .Recovery_fail              (Recovery_fail)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // LW xk, 4k(x0) with a zero register-image base.
    function automatic logic [31:0] exp_lw(input int k);
        logic [11:0] imm;
        logic [4:0]  rd;
        imm = 12'(4 * k);
        rd  = 5'(k);
        return {imm, 5'b00000, 3'b010, rd, 7'b0000011};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, 32'(Stall), 32'd0);
        check({tag, "_ivld"}, 32'(Inject_valid), 32'd0);
        check({tag, "_instr"}, Inject_instr, 32'd0);
        check({tag, "_sels"}, {30'd0, Recovery_Data_MemWrite_sel, Data_Recovery_sel}, 32'd0);
        check({tag, "_redir"}, {31'd0, PC_redirect_valid}, 32'd0);
        check({tag, "_rpc"}, PC_redirect, 32'd0);
        check({tag, "_busyfail"}, {30'd0, Recovery_busy, Recovery_fail}, 32'd0);
    endtask

    // Called at a falling edge: fault is sampled at the next rising edge.
    task automatic fault_pulse();
        Voter_state = 3'b000;
        @(negedge clk);
        Voter_state = 3'b111;
    endtask

    task automatic wait_inject(input string tag);
        int n = 0;
        while (!Inject_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(Inject_valid), 32'd1);
    endtask

    task automatic run_to_reg(input int k, input string tag);
        int n = 0;
        while (Inject_instr[11:7] != 5'(k) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(Inject_instr[11:7]), 32'(k));
    endtask

    // Consume the remaining reloads with ready=1, checking each one in order.
    task automatic finish_restore(input int start_r, input logic [31:0] exp_pc, input string tag);
        int r = start_r;
        int n = 0;
        Inject_ready = 1'b1;
        while (!PC_redirect_valid && n < 100) begin
            if (Inject_valid) begin
                check({tag, "_instr"}, Inject_instr, exp_lw(r));
                r++;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_nregs"}, 32'(r), 32'd32);
        check({tag, "_redir_vld"}, 32'(PC_redirect_valid), 32'd1);
        check({tag, "_redir_pc"}, PC_redirect, exp_pc);
        @(negedge clk);
        check({tag, "_stall_done"}, 32'(Stall), 32'd0);
    endtask

    initial begin
        // 1: reset state, checkpoint capture of 0x40
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        PC_voter_output = 32'h0000_0040;
        Ckpt_en = 1'b1;
        @(negedge clk);
        Ckpt_en = 1'b0;
        check_quiet("ckpt_idle");

        // 2: nominal recovery timing
        fault_pulse();
        check("t2_stall_T1", 32'(Stall), 32'd1);
        check("t2_busy_T1", 32'(Recovery_busy), 32'd1);
        repeat (3) @(negedge clk);
        check("t2_drain_T4", 32'(Inject_valid), 32'd0);
        @(negedge clk);
        check("t2_ivld_T5", 32'(Inject_valid), 32'd1);
        check("t2_first_lw", Inject_instr, 32'h0040_2083);
        check("t2_dsel", 32'(Data_Recovery_sel), 32'd1);
        check("t2_wsel", 32'(Recovery_Data_MemWrite_sel), 32'd1);
        repeat (30) @(negedge clk);
        check("t2_last_lw", Inject_instr, 32'h07C0_2F83);
        @(negedge clk);
        check("t2_redir_T36", 32'(PC_redirect_valid), 32'd1);
        check("t2_redir_pc", PC_redirect, 32'h0000_0040);
        check("t2_redir_stall", 32'(Stall), 32'd1);
        check("t2_redir_noinj", 32'(Inject_valid), 32'd0);
        @(negedge clk);
        check("t2_stall_T37", 32'(Stall), 32'd0);
        check("t2_redir_off", 32'(PC_redirect_valid), 32'd0);
        check("t2_rpc_off", PC_redirect, 32'd0);
        check("t2_busy_off", 32'(Recovery_busy), 32'd0);

        // 3: ready pattern 1,0,0,1 holds x2 stable
        fault_pulse();
        wait_inject("t3_restore");
        check("t3_x1", Inject_instr, exp_lw(1));
        @(negedge clk);
        check("t3_x2", Inject_instr, exp_lw(2));
        Inject_ready = 1'b0;
        @(negedge clk);
        check("t3_x2_hold1", Inject_instr, exp_lw(2));
        @(negedge clk);
        check("t3_x2_hold2", Inject_instr, exp_lw(2));
        Inject_ready = 1'b1;
        @(negedge clk);
        check("t3_x3", Inject_instr, exp_lw(3));
        finish_restore(3, 32'h0000_0040, "t3");

        // 4: two retries then FAIL on the third fault
        fault_pulse();
        wait_inject("t4_restore0");
        for (int k = 1; k <= 2; k++) begin
            run_to_reg(10, "t4_at_r10");
            fault_pulse();
            check("t4_redrain", 32'(Inject_valid), 32'd0);
            check("t4_redrain_stall", 32'(Stall), 32'd1);
            check("t4_nofail", 32'(Recovery_fail), 32'd0);
            wait_inject("t4_restore_again");
            check("t4_restart_x1", Inject_instr, exp_lw(1));
        end
        run_to_reg(10, "t4_at_r10_final");
        fault_pulse();
        check("t4_fail", 32'(Recovery_fail), 32'd1);
        check("t4_fail_stall", 32'(Stall), 32'd1);
        check("t4_fail_busy", 32'(Recovery_busy), 32'd1);
        check("t4_fail_ivld", 32'(Inject_valid), 32'd0);
        check("t4_fail_instr", Inject_instr, 32'd0);
        Ckpt_en = 1'b1;
        repeat (10) @(negedge clk);
        Ckpt_en = 1'b0;
        check("t4_fail_sticky", 32'(Recovery_fail), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t4_fail_cleared", 32'(Recovery_fail), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 5: capture blocked on fault cycle and during DRAIN
        PC_voter_output = 32'h0000_0040;
        Ckpt_en = 1'b1;
        @(negedge clk);
        PC_voter_output = 32'h0000_0090;
        Voter_state = 3'b000;
        @(negedge clk);
        Voter_state = 3'b111;
        PC_voter_output = 32'h0000_0080;
        @(negedge clk);
        Ckpt_en = 1'b0;
        wait_inject("t5_restore");
        finish_restore(1, 32'h0000_0040, "t5");

        // 6: async reset mid-RESTORE, checkpoint returns to RESET_PC
        fault_pulse();
        wait_inject("t6_restore");
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_idle_stall", 32'(Stall), 32'd0);
        fault_pulse();
        wait_inject("t6_restore2");
        finish_restore(1, 32'h0000_0000, "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
